// File: rtl/mdu_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : mdu_ctrl_if
//  Purpose  : Bundles the EX-stage request signals and the HI/LO/busy
//             responses that connect the pipeline to the multiply/divide
//             controller.
//  Signals  : start, op[2:0], a, b     - request from EX (master drives)
//             busy, stall_req, hi, lo  - controller status/results
//  Modports : master (EX side / bench), slave (mdu_ctrl)
//  Revision : 1.0 - initial release
// ============================================================================
interface mdu_ctrl_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [2:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             stall_req;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output start, op, a, b,
      input  busy, stall_req, hi, lo
   );

   modport slave (
      input  start, op, a, b,
      output busy, stall_req, hi, lo
   );
endinterface
`default_nettype wire

// File: rtl/mdu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mdu_ctrl
//  Purpose  : Multi-cycle multiply/divide controller for the MIPS EX stage.
//             Results are computed when an op is accepted, held in pending
//             registers, and committed to HI/LO after a fixed busy latency.
//  Ports    : clk        - system clock, rising edge
//             reset      - asynchronous, active-high, clears all state
//             bus        - mdu_ctrl_if.slave (start/op/a/b in,
//                          busy/stall_req/hi/lo out)
//  Options  : MDU_MADD_EN - when defined, op 6 (MADD) and op 7 (MSUB)
//             accumulate into {hi,lo}; otherwise they are no-ops.
//  Revision : 1.0 - initial release
// ============================================================================
module mdu_ctrl #(
   parameter int WIDTH      = 32,
   parameter int MUL_CYCLES = 5,
   parameter int DIV_CYCLES = 10
) (
   input  logic       clk,
   input  logic       reset,
   mdu_ctrl_if.slave  bus
);

   localparam int         DW       = 2 * WIDTH;
   localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES - 1);
   localparam logic [3:0] DIV_LOAD = 4'(DIV_CYCLES - 1);

   localparam logic [2:0] OP_MULT  = 3'd0;
   localparam logic [2:0] OP_MULTU = 3'd1;
   localparam logic [2:0] OP_DIV   = 3'd2;
   localparam logic [2:0] OP_DIVU  = 3'd3;
   localparam logic [2:0] OP_MTHI  = 3'd4;
   localparam logic [2:0] OP_MTLO  = 3'd5;
   localparam logic [2:0] OP_MADD  = 3'd6;
   localparam logic [2:0] OP_MSUB  = 3'd7;

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic             busy_q, busy_d;
   logic [3:0]       count_q, count_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic [WIDTH-1:0] pend_hi_q, pend_hi_d;
   logic [WIDTH-1:0] pend_lo_q, pend_lo_d;
   logic             pend_wr_q, pend_wr_d;   // 0 => divide by zero, leave HI/LO alone

   // ------------------------------------------------------------------------
   // Datapath: products and quotient/remainder from the live operands.
   // The signed product is taken as the low 2*WIDTH bits of the product of
   // sign-extended operands, which is exact modulo 2^(2*WIDTH).
   // ------------------------------------------------------------------------
   logic [DW-1:0]    a_sx, b_sx, prod_s, prod_u;
   logic             a_neg, b_neg, is_sdiv, is_div, div_zero;
   logic [WIDTH-1:0] a_mag, b_mag, div_n, div_d;
   logic [WIDTH-1:0] quo_u, rem_u, quo_s, rem_s;
   logic [DW-1:0]    result;
   logic             is_long;

   assign a_sx   = {{WIDTH{bus.a[WIDTH-1]}}, bus.a};
   assign b_sx   = {{WIDTH{bus.b[WIDTH-1]}}, bus.b};
   assign prod_s = a_sx * b_sx;
   assign prod_u = {{WIDTH{1'b0}}, bus.a} * {{WIDTH{1'b0}}, bus.b};

   assign is_sdiv  = (bus.op == OP_DIV);
   assign is_div   = (bus.op == OP_DIV) || (bus.op == OP_DIVU);
   assign div_zero = (bus.b == '0);

   // Signed division runs on magnitudes through the same unsigned divider.
   // This also yields the MIN/-1 case naturally: |MIN| / 1 = MIN, rem 0.
   assign a_neg = is_sdiv & bus.a[WIDTH-1];
   assign b_neg = is_sdiv & bus.b[WIDTH-1];
   assign a_mag = a_neg ? (~bus.a + 1'b1) : bus.a;
   assign b_mag = b_neg ? (~bus.b + 1'b1) : bus.b;
   assign div_n = a_mag;
   // A zero divisor is swapped for 1 so the divider never sees 0; the
   // result is discarded at commit anyway.
   assign div_d = div_zero ? WIDTH'(1) : b_mag;
   assign quo_u = div_n / div_d;
   assign rem_u = div_n % div_d;
   assign quo_s = (a_neg ^ b_neg) ? (~quo_u + 1'b1) : quo_u;
   assign rem_s = a_neg ? (~rem_u + 1'b1) : rem_u;

   always_comb begin
      result  = {hi_q, lo_q};
      is_long = 1'b0;
      case (bus.op)
         OP_MULT:  begin result = prod_s;         is_long = 1'b1; end
         OP_MULTU: begin result = prod_u;         is_long = 1'b1; end
         OP_DIV,
         OP_DIVU:  begin result = {rem_s, quo_s}; is_long = 1'b1; end
`ifdef MDU_MADD_EN
         // Accumulator is the architectural {hi,lo} at the accepting edge.
         OP_MADD:  begin result = {hi_q, lo_q} + prod_s; is_long = 1'b1; end
         OP_MSUB:  begin result = {hi_q, lo_q} - prod_s; is_long = 1'b1; end
`endif
         default:  begin result = {hi_q, lo_q}; is_long = 1'b0; end
      endcase
   end

   // ------------------------------------------------------------------------
   // Control FSM: next state and register updates
   // ------------------------------------------------------------------------
   always_comb begin
      state_d   = state_q;
      busy_d    = busy_q;
      count_d   = count_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      pend_hi_d = pend_hi_q;
      pend_lo_d = pend_lo_q;
      pend_wr_d = pend_wr_q;

      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               if (is_long) begin
                  pend_hi_d = result[DW-1:WIDTH];
                  pend_lo_d = result[WIDTH-1:0];
                  pend_wr_d = !(is_div && div_zero);
                  count_d   = is_div ? DIV_LOAD : MUL_LOAD;
                  busy_d    = 1'b1;
                  state_d   = S_RUN;
               end else if (bus.op == OP_MTHI) begin
                  hi_d = bus.a;
               end else if (bus.op == OP_MTLO) begin
                  lo_d = bus.a;
               end
            end
         end
         S_RUN: begin
            // Any start arriving here is ignored: the hazard unit holds it.
            if (count_q == 4'd0) begin
               if (pend_wr_q) begin
                  hi_d = pend_hi_q;
                  lo_d = pend_lo_q;
               end
               busy_d  = 1'b0;
               state_d = S_IDLE;
            end else begin
               count_d = count_q - 4'd1;
            end
         end
         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         busy_q    <= 1'b0;
         count_q   <= 4'd0;
         hi_q      <= '0;
         lo_q      <= '0;
         pend_hi_q <= '0;
         pend_lo_q <= '0;
         pend_wr_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         busy_q    <= busy_d;
         count_q   <= count_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         pend_hi_q <= pend_hi_d;
         pend_lo_q <= pend_lo_d;
         pend_wr_q <= pend_wr_d;
      end
   end

   assign bus.busy      = busy_q;
   assign bus.stall_req = busy_q | (bus.start & is_long);
   assign bus.hi        = hi_q;
   assign bus.lo        = lo_q;

endmodule
`default_nettype wire

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
- Multi-cycle multiply/divide unit controller for the pipelined MIPS CPU. Sits beside the EX-stage ALU.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from EX and captures operands.
- Models the multi-cycle latency with a countdown while holding busy, then commits results to the HI/LO architectural registers.
- Produces the stall request the hazard unit uses to block MFHI/MFLO and new MDU ops while an operation is in flight.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- MUL_CYCLES, 5, busy cycles for MULT/MULTU (and MADD/MSUB), range 1..15.
- DIV_CYCLES, 10, busy cycles for DIV/DIVU, range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- start  input  1  op valid from EX this cycle.
- op  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MADD, 7 MSUB.
- a  input  WIDTH  rs operand.
- b  input  WIDTH  rt operand.
- busy  output  1  registered; high while an op is counting down.
- stall_req  output  1  combinational: busy | (start & op is 0..3 or enabled 6/7).
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- States: IDLE, RUN.
- Reset (async, any time including mid-RUN):
  - state=IDLE, busy=0, count=0, hi=0, lo=0.
  - Pending results are discarded.
- IDLE with start and op in 0..3 (edge E0):
  - Results are computed combinationally from a/b and latched into pend_hi/pend_lo.
  - count=N-1, where N=MUL_CYCLES or DIV_CYCLES.
  - busy=1, state=RUN.
- RUN:
  - count decrements each edge.
  - At the edge where count==0: hi/lo <= pend_hi/pend_lo, busy=0, state=IDLE.
  - busy is high for exactly N cycles after E0.
  - New hi/lo values are visible in the same cycle busy first reads 0.
- MTHI/MTLO in IDLE: hi<=a or lo<=a at the next edge. No busy, no stall.
- start while busy (any op, including MTHI/MTLO): ignored. The hazard unit guarantees this via stall_req; the bench checks it anyway.
- start with N==1: busy for 1 cycle; commit at the following edge.
- MULT: {hi,lo} = signed(a)*signed(b), 2*WIDTH-bit product. MULTU: the unsigned product.
- DIV (signed):
  - lo = quotient truncated toward zero.
  - hi = remainder, with the sign of the dividend.
  - Overflow case a=0x80000000, b=0xFFFFFFFF: lo=0x80000000, hi=0.
- DIVU: unsigned quotient to lo, remainder to hi.
- Divide by zero (b==0, DIV or DIVU):
  - Full busy latency still applies.
  - hi and lo remain unchanged at commit.
- Operands are sampled only at E0. a/b changes during RUN have no effect.

Optional Feature:
- Macro MDU_MADD_EN.
- Defined:
  - op 6 MADD: {hi,lo} <= {hi,lo} + signed(a)*signed(b).
  - op 7 MSUB: {hi,lo} <= {hi,lo} - signed(a)*signed(b).
  - Both are 64-bit, wrap modulo 2^64, take MUL_CYCLES latency, and are included in stall_req.
  - The accumulator operand is the {hi,lo} value at E0.
- Not defined: ops 6/7 are no-ops. No busy, no stall_req, hi/lo unchanged.

Test Plan:
- DIV a=0xFFFFFFF9 (-7), b=2 -> busy high 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF; stall_req high in the start cycle and throughout RUN.
- MULTU a=0xFFFFFFFF, b=2 -> after 5 busy cycles hi=0x00000001, lo=0xFFFFFFFE. MULT a=0xFFFFFFFE, b=3 -> hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- Preload MTHI 0x11, MTLO 0x22 (next-edge update, busy stays 0); then DIVU a=5, b=0 -> 10 busy cycles, hi=0x11, lo=0x22 unchanged. Then DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- Start DIVU 0xFFFFFFF9/2, then assert start MTLO a=0xABCD in RUN cycle 3 -> ignored; final lo=0x7FFFFFFC, hi=1.
- Start MULT, assert reset in RUN cycle 2 -> busy, hi and lo drop to 0 immediately (asynchronously); no commit after reset release.
- With MDU_MADD_EN: hi=0, lo=0xFFFFFFFF, MADD a=1, b=1 -> hi=1, lo=0. Without the macro: the same op leaves busy=0 and hi/lo unchanged.
